// File: rtl/bullet_line_scanner_if.sv
// Read port of the bullet table: the scanner drives the index, the table
// answers combinationally with the selected entry's fields.
interface bullet_line_scanner_if;
    logic [2:0]  index;
    logic [15:0] position;   // [15:8]=x, [7:0]=y
    logic [15:0] size;       // [15:8]=width, [7:0]=height
    logic [2:0]  color;
    logic        isRender;

    modport master (output index, input position, size, color, isRender);
    modport slave  (input index, output position, size, color, isRender);
endinterface

// File: rtl/bullet_line_scanner.sv
// Per-scanline bullet reader: walks the 8 table entries at line start,
// keeps up to SLOTS bullets overlapping the line, then answers per-pixel
// hit/colour queries against those slots with one cycle of latency.
module bullet_line_scanner #(
    parameter int SLOTS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          line_start,
    input  logic [7:0]                    line_y,
    input  logic                          pix_valid,
    input  logic [7:0]                    px,
    bullet_line_scanner_if.master         tbl,
    output logic                          scan_busy,
    output logic                          pix_hit,
    output logic [2:0]                    pix_color,
    output logic                          line_overflow
);
    localparam int CW = $clog2(SLOTS + 1);
    localparam logic [CW-1:0] SLOTS_C = CW'(SLOTS);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                idx_q, idx_d;
    logic [7:0]                row_q, row_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic [SLOTS-1:0]          slot_vld_q, slot_vld_d;
    logic [SLOTS-1:0][7:0]     slot_x_q, slot_x_d;
    logic [SLOTS-1:0][7:0]     slot_w_q, slot_w_d;
    logic [SLOTS-1:0][2:0]     slot_c_q, slot_c_d;
    logic                      pix_hit_q, pix_hit_d;
    logic [2:0]                pix_color_q, pix_color_d;

    logic [7:0] ent_x, ent_y, ent_w, ent_h;
    logic [8:0] ent_bot;
    logic       ent_hit;
    logic [SLOTS-1:0] slot_hit;

    assign ent_x   = tbl.position[15:8];
    assign ent_y   = tbl.position[7:0];
    assign ent_w   = tbl.size[15:8];
    assign ent_h   = tbl.size[7:0];
    // 9-bit bottom edge so bullets straddling row 255 still cover their rows
    assign ent_bot = {1'b0, ent_y} + {1'b0, ent_h};
    assign ent_hit = tbl.isRender && ({1'b0, row_q} >= {1'b0, ent_y}) &&
                     ({1'b0, row_q} < ent_bot);

    assign tbl.index     = idx_q;
    assign scan_busy     = (state_q == SCAN);
    assign pix_hit       = pix_hit_q;
    assign pix_color     = pix_color_q;
    assign line_overflow = ovf_q;

    // Per-slot horizontal coverage of the current pixel, 9-bit right edge
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic [8:0] right;
        assign right       = {1'b0, slot_x_q[i]} + {1'b0, slot_w_q[i]};
        assign slot_hit[i] = slot_vld_q[i] && (px >= slot_x_q[i]) &&
                             ({1'b0, px} < right);
    end

    // Scan FSM: line_start (re)starts from entry 0, hits fill slots in order
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        slot_vld_d = slot_vld_q;
        slot_x_d   = slot_x_q;
        slot_w_d   = slot_w_q;
        slot_c_d   = slot_c_q;
        if (line_start) begin
            state_d    = SCAN;
            idx_d      = 3'd0;
            row_d      = line_y;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            slot_vld_d = '0;
        end else if (state_q == SCAN) begin
            if (ent_hit) begin
                if (cnt_q < SLOTS_C) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (cnt_q == CW'(i)) begin
                            slot_vld_d[i] = 1'b1;
                            slot_x_d[i]   = ent_x;
                            slot_w_d[i]   = ent_w;
                            slot_c_d[i]   = tbl.color;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (idx_q == 3'd7) begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // Pixel stage: lowest-numbered covering slot wins; muted while scanning
    always_comb begin
        pix_hit_d   = 1'b0;
        pix_color_d = 3'b000;
        if (pix_valid && (state_q != SCAN) && !line_start) begin
            for (int i = SLOTS - 1; i >= 0; i--) begin
                if (slot_hit[i]) begin
                    pix_hit_d   = 1'b1;
                    pix_color_d = slot_c_q[i];
                end
            end
        end
    end

    // State and output registers, async reset aborts any scan in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            row_q       <= 8'd0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            slot_vld_q  <= '0;
            slot_x_q    <= '0;
            slot_w_q    <= '0;
            slot_c_q    <= '0;
            pix_hit_q   <= 1'b0;
            pix_color_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            slot_vld_q  <= slot_vld_d;
            slot_x_q    <= slot_x_d;
            slot_w_q    <= slot_w_d;
            slot_c_q    <= slot_c_d;
            pix_hit_q   <= pix_hit_d;
            pix_color_q <= pix_color_d;
        end
    end
endmodule

// File: doc/bullet_line_scanner.md
# bullet_line_scanner

Per-scanline reader for the bullet table. At the start of each line it walks all eight bullet entries through the table's index read port and keeps up to SLOTS bullets that overlap the line. During active pixels it reports whether the current pixel is covered by a bullet, and with which colour. It sits between the VGA timing/pixel-coordinate logic and the pixel colour mux, as the consumer of the bullet table's index/position/size/colour/isRender read interface.

## Interface
- SLOTS, 4, number of per-line bullet slots (1..8)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- line_start  in  1  one-cycle pulse: begin scanning for line line_y
- line_y  in  8  game-space row of the line to be rendered; sampled on line_start
- pix_valid  in  1  pixel px,py is in the active area this cycle
- px  in  8  game-space column of the current pixel
- index  out  3  bullet table read index (registered)
- position  in  16  [15:8]=x, [7:0]=y of entry at index, combinational same-cycle read
- size  in  16  [15:8]=width, [7:0]=height of entry at index
- color  in  3  000 white, 001 green, 010 blue
- isRender  in  1  entry is live
- scan_busy  out  1  scan in progress
- pix_hit  out  1  registered: pixel covered by a bullet
- pix_color  out  3  registered colour of covering bullet, 000 when no hit
- line_overflow  out  1  more than SLOTS bullets overlap the current line

## Operation
- States: IDLE, SCAN.
- IDLE → SCAN on line_start: idx←0, all slots invalid, slot count←0, line_overflow←0, latched row←line_y.
- SCAN, each cycle: evaluate the entry at idx. The entry is a line hit when isRender=1 and row ≥ y and row < y+height. Compare in 9 bits, so y+height up to 510 is valid; height 0 never hits.
- On a hit with slot count < SLOTS: store x, width and colour into slot[count], mark it valid, and increment count.
- On a hit with count = SLOTS: drop the entry and set line_overflow←1. It stays set until the next line_start.
- idx=7 evaluated → IDLE, idx←0. No wrap-around beyond 7.
- line_start during SCAN restarts the scan: idx←0, slots cleared, new row latched. The partial scan is discarded.
- Slots are filled in ascending index order. Lower slot number has display priority.
- Pixel stage, every cycle:
  - If pix_valid=1 and not in SCAN: the pixel hits a slot when the slot is valid and px ≥ x and px < x+width (9-bit arithmetic).
  - pix_hit←OR of slot hits. pix_color←colour of the lowest-numbered hitting slot, or 000 if none.
  - If pix_valid=0 or in SCAN: pix_hit←0, pix_color←000.
- Slot contents persist after the scan until the next line_start. A line may be displayed repeatedly without rescanning.
- Table entries are read only while in SCAN. Table changes after the scan do not affect the current line.

## Timing
- Reset values: state IDLE, index=0, scan_busy=0, pix_hit=0, pix_color=000, line_overflow=0, all slots invalid.
- Reset asserted mid-scan aborts immediately to these values.
- Edge E0 samples line_start=1. From E0, index=0 and scan_busy=1.
- Edges E1..E8 evaluate entries 0..7, one per cycle. After E8, scan_busy=0 and index=0.
  - scan_busy is high for exactly 8 cycles.
  - line_overflow can rise at E1..E8.
- line_start must lead the first active pixel by at least 9 cycles, or those pixels read as no-hit.
- Pixel latency is 1 cycle: pix_hit/pix_color at edge N+1 reflect px/pix_valid present before edge N+1.
- line_start and pix_valid high in the same cycle: the scan starts and the pixel output is 0.

## Test plan
- Entry 0 live, x=64, y=3, w=3, h=3, colour 000; other entries dead. line_start with line_y=4, then sweep px 60..70 → pix_hit=1 only for px 64,65,66, pix_color=000.
- Same table, line_y=6 (=y+h) → no hits. line_y=3 → hits at px 64..66.
- Entries 0 and 1 both cover line 10 and overlap at px 80, with colours 000 and 001 → pix_color=000 at px 80 (priority to entry 0). Where only entry 1 covers, pix_color=001.
- Five live entries covering line 20, SLOTS=4 → line_overflow=1 after the scan. Entry 4 never hits. line_overflow clears on the next line_start.
- line_start pulsed again 3 cycles into a scan with a new line_y → scan_busy stays high 8 cycles from the second pulse. Results match the new line only.
- Entry with y=250, h=10, line_y=255, x=250, w=10 → hits at px 250..255 (9-bit compare). Reset asserted mid-scan → all outputs return to reset values asynchronously.
